// File: rtl/seq_carry_increment_adder.sv
// seq_carry_increment_adder: block-serial carry-increment adder/subtractor with start/busy/done handshake
module seq_carry_increment_adder #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);
    localparam int NBLK = WIDTH / BLOCK;
    localparam int KW = (NBLK > 1) ? $clog2(NBLK) : 1;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN = 1'b1;
    localparam logic [KW-1:0] K_LAST = KW'(NBLK - 1);

    logic [1:0]       rst_sync_q, rst_sync_d;
    logic             rst_core_n;
    logic [0:0]       state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, sum_q, sum_d;
    logic             c_q, c_d, done_q, done_d, carry_out_q, carry_out_d, overflow_q, overflow_d;
    logic [BLOCK-1:0] sa, sb;
    logic [BLOCK:0]   s0, s1, sel;
    logic             msb_cin;

    assign rst_sync_d = {rst_sync_q[0], 1'b1};
    assign rst_core_n = rst_sync_q[1];

    // Reset asserts immediately but releases only on a clock edge, so busy/done never glitch on deassertion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= 2'b00;
        else        rst_sync_q <= rst_sync_d;
    end

    // Slice datapath plus the IDLE/RUN next-state logic
    always_comb begin
        sa = a_q[k_q*BLOCK +: BLOCK];
        sb = b_q[k_q*BLOCK +: BLOCK];
        s0 = {1'b0, sa} + {1'b0, sb};
        s1 = {1'b0, sa} + {1'b0, sb} + {{BLOCK{1'b0}}, 1'b1};
        sel = c_q ? s1 : s0;
        msb_cin = sa[BLOCK-1] ^ sb[BLOCK-1] ^ sel[BLOCK-1];
        state_d = state_q;
        k_d = k_q;
        a_d = a_q;
        b_d = b_q;
        c_d = c_q;
        acc_d = acc_q;
        sum_d = sum_q;
        carry_out_d = carry_out_q;
        overflow_d = overflow_q;
        done_d = 1'b0;
        if (state_q == IDLE) begin
            if (start) begin
                a_d = a;
                b_d = sub ? ~b : b;
                c_d = sub | carry_in;
                k_d = '0;
                acc_d = '0;
                state_d = RUN;
            end
        end else begin
            acc_d[k_q*BLOCK +: BLOCK] = sel[BLOCK-1:0];
            c_d = sel[BLOCK];
            k_d = k_q + 1'b1;
            if (k_q == K_LAST) begin
                k_d = '0;
                state_d = IDLE;
                done_d = 1'b1;
                sum_d = acc_d;
                carry_out_d = sel[BLOCK];
                overflow_d = msb_cin ^ sel[BLOCK];
            end
        end
    end

    // State, operand, accumulator and result registers
    always_ff @(posedge clk or negedge rst_core_n) begin
        if (!rst_core_n) begin
            state_q <= IDLE;
            k_q <= '0;
            a_q <= '0;
            b_q <= '0;
            c_q <= 1'b0;
            acc_q <= '0;
            sum_q <= '0;
            carry_out_q <= 1'b0;
            overflow_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q <= k_d;
            a_q <= a_d;
            b_q <= b_d;
            c_q <= c_d;
            acc_q <= acc_d;
            sum_q <= sum_d;
            carry_out_q <= carry_out_d;
            overflow_q <= overflow_d;
            done_q <= done_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign sum = sum_q;
    assign carry_out = carry_out_q;
    assign overflow = overflow_q;
endmodule

// File: tb/tb_seq_carry_increment_adder.sv
// tb_seq_carry_increment_adder: scoreboard bench for 16-bit and 32-bit instances of the serial adder
module tb_seq_carry_increment_adder;
    typedef struct packed {
        logic [31:0] sum;
        logic        co;
        logic        ov;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start16 = 1'b0, start32 = 1'b0;
    logic        sub = 1'b0, cin = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic        busy16, done16, co16, ov16, busy32, done32, co32, ov32;
    logic [15:0] sum16;
    logic [31:0] sum32;
    int          checks = 0, errors = 0;
    exp_t        q16[$];
    exp_t        q32[$];

    seq_carry_increment_adder #(.WIDTH(16), .BLOCK(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .sub(sub), .a(a[15:0]), .b(b[15:0]),
        .carry_in(cin), .busy(busy16), .done(done16), .sum(sum16), .carry_out(co16), .overflow(ov16)
    );

    seq_carry_increment_adder #(.WIDTH(32), .BLOCK(4)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .sub(sub), .a(a), .b(b),
        .carry_in(cin), .busy(busy32), .done(done32), .sum(sum32), .carry_out(co32), .overflow(ov32)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] av, input logic [31:0] bv, input logic cv, input logic sv, input bit narrow);
        exp_t        r;
        logic [32:0] f;
        logic [31:0] be;
        logic        c0, cmsb;
        be = sv ? ~bv : bv;
        c0 = sv ? 1'b1 : cv;
        if (narrow) begin
            f = {17'b0, av[15:0]} + {17'b0, be[15:0]} + 33'(c0);
            r.sum = {16'b0, f[15:0]};
            r.co = f[16];
            cmsb = av[15] ^ be[15] ^ f[15];
        end else begin
            f = {1'b0, av} + {1'b0, be} + 33'(c0);
            r.sum = f[31:0];
            r.co = f[32];
            cmsb = av[31] ^ be[31] ^ f[31];
        end
        r.ov = cmsb ^ r.co;
        return r;
    endfunction

    always @(negedge clk) begin
        if (done16) begin
            if (q16.size() == 0) chk("spurious_done16", 32'(done16), 32'd0);
            else begin
                exp_t e;
                e = q16.pop_front();
                chk("sum16", {16'b0, sum16}, e.sum);
                chk("co16", 32'(co16), 32'(e.co));
                chk("ov16", 32'(ov16), 32'(e.ov));
            end
        end
    end

    always @(negedge clk) begin
        if (done32) begin
            if (q32.size() == 0) chk("spurious_done32", 32'(done32), 32'd0);
            else begin
                exp_t e;
                e = q32.pop_front();
                chk("sum32", sum32, e.sum);
                chk("co32", 32'(co32), 32'(e.co));
                chk("ov32", 32'(ov32), 32'(e.ov));
            end
        end
    end

    task automatic run(input bit w32, input logic [31:0] av, input logic [31:0] bv, input logic cv, input logic sv, input bit disturb);
        exp_t e;
        int   n, nb, nblk;
        nblk = w32 ? 8 : 4;
        e = model(av, bv, cv, sv, !w32);
        @(negedge clk);
        a = av; b = bv; cin = cv; sub = sv;
        if (w32) begin start32 = 1'b1; q32.push_back(e); end
        else begin start16 = 1'b1; q16.push_back(e); end
        @(negedge clk);
        start16 = 1'b0; start32 = 1'b0;
        n = 1; nb = 0;
        while (!(w32 ? done32 : done16) && n < 40) begin
            if (w32 ? busy32 : busy16) nb++;
            if (disturb && n == 3) begin
                start32 = w32; start16 = !w32;
                a = $urandom; b = $urandom; sub = ~sv; cin = ~cv;
            end
            if (disturb && n == 4) begin start32 = 1'b0; start16 = 1'b0; end
            @(negedge clk);
            n++;
        end
        chk("latency", 32'(n - 1), 32'(nblk));
        chk("busy_cycles", 32'(nb), 32'(nblk));
        @(negedge clk);
        chk("done_pulse_width", 32'(w32 ? done32 : done16), 32'd0);
        chk("sum_hold", w32 ? sum32 : {16'b0, sum16}, e.sum);
    endtask

    initial begin
        int n;
        #3;
        chk("rst_busy32", 32'(busy32), 32'd0);
        chk("rst_done32", 32'(done32), 32'd0);
        chk("rst_sum32", sum32, 32'd0);
        chk("rst_co_ov32", {30'b0, co32, ov32}, 32'd0);
        chk("rst_sum16", {16'b0, sum16}, 32'd0);
        chk("rst_busy_done16", {30'b0, busy16, done16}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (4) @(negedge clk);
        run(1'b0, 32'h1A2B, 32'h3C4D, 1'b0, 1'b0, 1'b0);
        run(1'b1, 32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0, 1'b0);
        run(1'b1, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0);
        run(1'b1, 32'd5, 32'd7, 1'b1, 1'b1, 1'b0);
        run(1'b1, 32'd7, 32'd5, 1'b0, 1'b1, 1'b0);
        run(1'b1, 32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b0, 1'b1);
        run(1'b0, 32'h8000, 32'h0001, 1'b0, 1'b1, 1'b1);
        run(1'b1, 32'h80000000, 32'h00000001, 1'b0, 1'b1, 1'b0);
        // Reset during the third RUN cycle discards the operation
        @(negedge clk);
        a = 32'hDEADBEEF; b = 32'h01010101; cin = 1'b0; sub = 1'b0; start32 = 1'b1;
        @(negedge clk); start32 = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy32), 32'd0);
        chk("midrst_sum", sum32, 32'd0);
        chk("midrst_co_ov_done", {29'b0, co32, ov32, done32}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (12) @(negedge clk);
        // Start held high across two operations on the 16-bit instance
        @(negedge clk);
        a = 32'h1A2B; b = 32'h3C4D; cin = 1'b0; sub = 1'b0; start16 = 1'b1;
        q16.push_back(model(32'h1A2B, 32'h3C4D, 1'b0, 1'b0, 1'b1));
        q16.push_back(model(32'hFFFF, 32'h0001, 1'b1, 1'b0, 1'b1));
        n = 0;
        while (!done16 && n < 20) begin @(negedge clk); n++; end
        chk("b2b_first_done", 32'(done16), 32'd1);
        a = 32'hFFFF; b = 32'h0001; cin = 1'b1;
        @(negedge clk); start16 = 1'b0;
        n = 1;
        while (!done16 && n < 20) begin @(negedge clk); n++; end
        chk("b2b_gap", 32'(n), 32'd5);
        repeat (12) @(negedge clk);
        chk("q16_drained", 32'(q16.size()), 32'd0);
        chk("q32_drained", 32'(q32.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_carry_increment_adder.md
# seq_carry_increment_adder

Block-serial, multi-cycle carry-increment adder/subtractor. It processes one BLOCK-bit slice per clock: each slice computes a carry-0 sum and a carry-1 sum, and the running carry selects between them. This trades latency for area against the single-cycle combinational carry_increment_adder. It sits in the datapath wherever a wide add/sub can tolerate WIDTH/BLOCK cycles of latency, and uses a start/busy/done handshake.

## Interface
- WIDTH, 32: operand and result width in bits; must be a multiple of BLOCK.
- BLOCK, 4: slice width processed per cycle; NBLK = WIDTH/BLOCK, NBLK ≥ 2.
- clk  input  1  rising-edge clock (single clock domain).
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only while idle (busy=0).
- sub  input  1  0 = a + b + carry_in; 1 = a − b (a + ~b + 1, carry_in ignored).
- a  input  WIDTH  operand A, sampled with start.
- b  input  WIDTH  operand B, sampled with start.
- carry_in  input  1  carry input for add mode, sampled with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; result is valid.
- sum  output  WIDTH  result; held from done until the next accepted start.
- carry_out  output  1  carry out of the MSB. In sub mode, 1 = no borrow.
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- The FSM has two states.
  - IDLE: busy=0. On a clk edge with start=1, the block latches a and b_eff = sub ? ~b : b. It latches c0 = sub ? 1 : carry_in. It clears the slice counter k to 0, clears the sum register, and moves to RUN.
  - RUN: busy=1. Each edge, for slice k:
    - s0 = a[k] + b_eff[k] + 0 and s1 = a[k] + b_eff[k] + 1, each BLOCK+1 bits.
    - Select by the running carry c: sum[k] ← c ? s1[BLOCK-1:0] : s0[BLOCK-1:0]; c ← c ? s1[BLOCK] : s0[BLOCK].
    - k increments. When k = NBLK−1:
      - Record carry_out.
      - overflow = (carry into bit WIDTH−1) XOR carry_out. The carry into bit WIDTH−1 is computed from the last slice's internal MSB-1 carry.
      - Assert done for the next cycle and return to IDLE.
- start is ignored while busy=1. Inputs may change freely during RUN because operands are latched.
- If start is held high, the block re-triggers on the first idle edge, which is the cycle done is high.
- sum, carry_out and overflow are updated only at completion.
  - Intermediate slice results live in an internal register; the sum port does not show partial results.
  - All three outputs hold their value until the next operation completes.
- Width rules:
  - The internal carry register is 1 bit.
  - Slice adders are BLOCK+1 bits.
  - No other sign extension; results wrap modulo 2^WIDTH.

## Timing
- Reset (rst_n=0, asynchronous, any state, including mid-RUN): state=IDLE, k=0, busy=0, done=0, sum=0, carry_out=0, overflow=0. Latched operands are cleared and any in-flight operation is discarded.
- Release of rst_n is synchronous to clk internally (no glitching of busy/done on deassertion).
- Latency: start is sampled at edge T0.
  - busy goes high after T0.
  - Slices 0..NBLK−1 are processed at edges T1..T_NBLK.
  - After T_NBLK: busy=0, done=1, and the result is valid.
  - done drops after T_NBLK+1.
  - Total is NBLK cycles from accept to done. Example: WIDTH=32, BLOCK=4 gives 8 cycles.
- Throughput: one operation per NBLK+1 cycles with start held high. The start accepted at edge T_NBLK+1 coincides with done falling.
- done never asserts without a preceding accepted start. Exactly one done pulse occurs per accepted start unless reset intervenes.

## Test plan
- Reset, then add with WIDTH=16, BLOCK=4: a=16'h1A2B, b=16'h3C4D, carry_in=0, sub=0 -> done after 4 cycles; sum=16'h5678, carry_out=0, overflow=0.
- WIDTH=32, BLOCK=4, add with wrap: a=32'hFFFFFFFF, b=32'h00000001, carry_in=1 -> done after 8 cycles; sum=32'h00000001, carry_out=1, overflow=0. Check that busy is high for exactly 8 cycles.
- WIDTH=32, signed overflow: a=32'h7FFFFFFF, b=32'h00000001, carry_in=0 -> sum=32'h80000000, carry_out=0, overflow=1.
- WIDTH=32, subtract with borrow: sub=1, a=5, b=7, carry_in=1 (ignored) -> sum=32'hFFFFFFFE, carry_out=0, overflow=0. Then sub=1, a=7, b=5 -> sum=2, carry_out=1.
- Mid-operation behaviour:
  - Pulse start again during RUN and change a and b during RUN -> ignored. The result matches the originally latched operands and there is a single done pulse.
  - Assert rst_n=0 at cycle 3 of RUN -> outputs go to 0 immediately, with no done pulse.
- Back-to-back: hold start=1 across two operations (1A2B+3C4D, then FFFF+0001+1 at WIDTH=16) -> done pulses spaced exactly NBLK+1 = 5 cycles apart, with results 5678/0 and 0001/1 respectively.
